periph_rx_arbiter: RTL
======================

Name: periph_rx_arbiter

Overview:
- Upstream end of the peripheral RX path: drains the RX FIFOs of all peripheral blocks and serialises their packets onto the single USB-bound stream.
- Arbitrates round-robin among non-empty, ready peripherals; almost-full FIFOs get priority.
- Reads each FIFO over its 1-cycle-latency read port and presents registered packets to the USB transmit logic with a valid/ready handshake.

Parameters:
- NUM_PERIPHS, default num_peripherals (8), number of peripheral RX FIFOs served.
- MAX_BURST, default 16, maximum consecutive packets taken from one peripheral per grant.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- periph_rx_data  input  NUM_PERIPHS x usb_packet_width  per-peripheral RX FIFO dout; address field already in top periph_address_width bits
- periph_rx_empty  input  NUM_PERIPHS  per-peripheral RX FIFO empty
- periph_rx_almost_full  input  NUM_PERIPHS  per-peripheral RX FIFO prog_full
- periph_ready  input  NUM_PERIPHS  per-peripheral post-reset ready flag
- periph_rx_read  output  NUM_PERIPHS  one-hot read strobe, at most 1 bit high
- usb_data  output  usb_packet_width  registered packet to USB transmit logic
- usb_valid  output  1  usb_data valid
- usb_ready  input  1  USB side accepts usb_data this cycle
- grant_idx  output  $clog2(NUM_PERIPHS)  currently granted peripheral
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst low, async): state IDLE; periph_rx_read=0, usb_data=0, usb_valid=0, grant_idx=0, busy=0, rr pointer=0, burst_cnt=0. Reset mid-burst abandons the in-flight packet. No FIFO read is issued during reset.
- Eligibility: req[i] = !periph_rx_empty[i] & periph_ready[i]. Urgent set = req & periph_rx_almost_full.
- Pick: if the urgent set is non-empty, round-robin over the urgent set, otherwise over req. Search starts at rr pointer, wraps NUM_PERIPHS-1 -> 0.
- FSM states are IDLE, FETCH, LATCH, SEND.
- IDLE: if any req, register grant_idx=pick, burst_cnt=0, go FETCH. Otherwise stay.
- FETCH (1 cycle): periph_rx_read[grant_idx]=1, go LATCH.
- LATCH (1 cycle): capture periph_rx_data[grant_idx] into usb_data, set usb_valid=1, go SEND.
- SEND: hold usb_data/usb_valid stable while !usb_ready.
- On usb_valid & usb_ready with burst_cnt < MAX_BURST-1, req[grant_idx]=1 and no urgent request from another peripheral:
  - assert periph_rx_read[grant_idx] in the same cycle
  - clear usb_valid
  - burst_cnt++
  - go LATCH
- On accept otherwise: usb_valid=0, rr pointer = grant_idx+1 (mod NUM_PERIPHS), go IDLE.
- Throughput: 1 packet per 2 cycles within a burst with usb_ready held high. First packet appears 3 cycles after the IDLE decision.
- Never read a FIFO whose empty flag is high in that cycle. Never assert two read strobes.
- Data is passed through unmodified; the address field is not rewritten.
- periph_ready dropping mid-burst: the current packet completes and the burst ends at its acceptance.
- busy=1 in FETCH/LATCH/SEND.

Decomposition:
- lycan_globals gains:
  - num_peripherals constant
  - rx_max_burst constant
  - typedef enum rx_arb_state_t {IDLE, FETCH, LATCH, SEND}
- One sub-module, lycan_rr_pick: combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: index, any.
  - Instantiated twice (urgent set and full set).

Test Plan:
- Reset then peripheral 2 non-empty with 3 packets, usb_ready=1 -> 3 packets in order on usb_data, one rx_read pulse each, valid every 2nd cycle, back to IDLE, pointer=3.
- Peripherals 0 and 5 each hold 2 packets, pointer=0 -> peripheral 0 burst of 2, then peripheral 5 burst of 2, grant_idx 0 then 5.
- Peripheral 1 holds 20 packets, MAX_BURST=16, peripheral 4 holds 1 -> 16 from peripheral 1, 1 from peripheral 4, remaining 4 from peripheral 1.
- Peripheral 0 bursting, peripheral 6 asserts almost_full -> burst ends after the current accept, next grant_idx=6.
- usb_ready held low 10 cycles in SEND -> usb_data/usb_valid stable, no further rx_read. Release -> single accept.
- rst low during LATCH -> all outputs 0 within the cycle. After release no rx_read until req is re-evaluated from IDLE.

Source files
------------

// File: rtl/lycan_globals.sv
// Shared constants and types for the Lycan peripheral/USB datapath.
package lycan_globals;

    localparam int num_peripherals      = 8;
    localparam int rx_max_burst         = 16;
    localparam int usb_packet_width     = 32;
    localparam int periph_address_width = 3;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LATCH,
        SEND
    } rx_arb_state_t;

endpackage

// File: rtl/lycan_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping.
module lycan_rr_pick #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] pos;

    always_comb begin
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = 0; k < N; k++) begin
            pos = IW'((int'(ptr) + k) % N);
            if (!any && req[pos]) begin
                idx = pos;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/periph_rx_arbiter.sv
// Drains the peripheral RX FIFOs round-robin (almost-full first) onto the
// single registered USB-bound packet stream.
module periph_rx_arbiter
    import lycan_globals::*;
#(
    parameter int NUM_PERIPHS = num_peripherals,
    parameter int MAX_BURST   = rx_max_burst
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [NUM_PERIPHS-1:0][usb_packet_width-1:0]     periph_rx_data,
    input  logic [NUM_PERIPHS-1:0]                           periph_rx_empty,
    input  logic [NUM_PERIPHS-1:0]                           periph_rx_almost_full,
    input  logic [NUM_PERIPHS-1:0]                           periph_ready,
    output logic [NUM_PERIPHS-1:0]                           periph_rx_read,
    output logic [usb_packet_width-1:0]                      usb_data,
    output logic                                             usb_valid,
    input  logic                                             usb_ready,
    output logic [$clog2(NUM_PERIPHS)-1:0]                   grant_idx,
    output logic                                             busy
);

    localparam int IW = $clog2(NUM_PERIPHS);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    rx_arb_state_t               state_q, state_d;
    logic [IW-1:0]               grant_q, grant_d;
    logic [IW-1:0]               rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]               burst_cnt_q, burst_cnt_d;
    logic [usb_packet_width-1:0] usb_data_q, usb_data_d;
    logic                        usb_valid_q, usb_valid_d;

    logic [NUM_PERIPHS-1:0] req, urgent, grant_mask;
    logic [IW-1:0]          urg_idx, all_idx, pick_idx;
    logic                   urg_any, all_any;
    logic                   accept, other_urgent, can_continue;

    assign req    = ~periph_rx_empty & periph_ready;
    assign urgent = req & periph_rx_almost_full;

    lycan_rr_pick #(.N(NUM_PERIPHS), .IW(IW)) u_pick_urgent (
        .req (urgent),
        .ptr (rr_ptr_q),
        .idx (urg_idx),
        .any (urg_any)
    );

    lycan_rr_pick #(.N(NUM_PERIPHS), .IW(IW)) u_pick_all (
        .req (req),
        .ptr (rr_ptr_q),
        .idx (all_idx),
        .any (all_any)
    );

    assign pick_idx     = urg_any ? urg_idx : all_idx;
    assign grant_mask   = NUM_PERIPHS'(1) << grant_q;
    assign other_urgent = |(urgent & ~grant_mask);
    assign accept       = usb_valid_q & usb_ready;
    // A burst keeps going only while the granted FIFO can safely be read again.
    assign can_continue = (burst_cnt_q < BW'(MAX_BURST - 1)) && req[grant_q] && !other_urgent;

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        rr_ptr_d       = rr_ptr_q;
        burst_cnt_d    = burst_cnt_q;
        usb_data_d     = usb_data_q;
        usb_valid_d    = usb_valid_q;
        periph_rx_read = '0;
        case (state_q)
            IDLE: begin
                if (all_any) begin
                    grant_d     = pick_idx;
                    burst_cnt_d = '0;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                if (!periph_rx_empty[grant_q]) begin
                    periph_rx_read[grant_q] = 1'b1;
                    state_d                 = LATCH;
                end else begin
                    state_d = IDLE;
                end
            end
            LATCH: begin
                usb_data_d  = periph_rx_data[grant_q];
                usb_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                if (accept) begin
                    usb_valid_d = 1'b0;
                    if (can_continue) begin
                        periph_rx_read[grant_q] = 1'b1;
                        burst_cnt_d             = burst_cnt_q + 1'b1;
                        state_d                 = LATCH;
                    end else begin
                        rr_ptr_d = (grant_q == IW'(NUM_PERIPHS - 1)) ? '0 : grant_q + 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            usb_data_q  <= '0;
            usb_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            usb_data_q  <= usb_data_d;
            usb_valid_q <= usb_valid_d;
        end
    end

    assign usb_data  = usb_data_q;
    assign usb_valid = usb_valid_q;
    assign grant_idx = grant_q;
    assign busy      = (state_q != IDLE);

endmodule
